// File: rtl/operand_dispatcher.sv
// Operand dispatcher: queues 8-bit operand triples and issues them one at a time
// to a compute core, tracking completions, aborting jobs that exceed TIMEOUT WAIT cycles.
module operand_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [7:0]               in_x,
   input  logic [7:0]               in_y,
   input  logic [7:0]               in_z,
   output logic                     in_ready,
   output logic [7:0]               core_x,
   output logic [7:0]               core_y,
   output logic [7:0]               core_z,
   output logic                     core_start,
   input  logic                     core_done,
   output logic                     busy,
   output logic [7:0]               job_count,
   output logic                     timeout_err,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [23:0]   r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_wr_vis;
   logic [AW:0]   r_rd_ptr;
   logic [AW:0]   r_level;
   logic [7:0]    r_core_x;
   logic [7:0]    r_core_y;
   logic [7:0]    r_core_z;
   logic [7:0]    r_job_count;
   logic          r_timeout_err;
   logic          r_done_prev;
   logic [CW-1:0] r_wait_cnt;

   logic w_push;
   logic w_pop;
   logic w_has_data;
   logic w_done_edge;
   logic w_complete;
   logic w_timeout;

   // in_ready is forced low for the whole reset assertion.
   assign in_ready    = ~rst & (r_level != FULL_LEVEL);
   assign w_push      = in_valid & in_ready;
   // The pop side sees a write one cycle late, so a fresh triple settles in RAM before issue.
   assign w_has_data  = (r_wr_vis != r_rd_ptr);
   assign w_done_edge = core_done & ~r_done_prev;

   assign core_x      = r_core_x;
   assign core_y      = r_core_y;
   assign core_z      = r_core_z;
   assign core_start  = (r_state == S_ISSUE);
   assign busy        = (r_state != S_IDLE);
   assign job_count   = r_job_count;
   assign timeout_err = r_timeout_err;
   assign fifo_level  = r_level;

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_complete   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_has_data) begin
               w_pop        = 1'b1;
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: w_state_next = S_WAIT;
         S_WAIT: begin
            // A done edge on the expiry cycle still counts as a completion.
            if (w_done_edge) begin
               w_complete   = 1'b1;
               w_state_next = S_IDLE;
            end else if (r_wait_cnt == LAST_WAIT) begin
               w_timeout    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {in_x, in_y, in_z};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_wr_vis      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_core_x      <= '0;
         r_core_y      <= '0;
         r_core_z      <= '0;
         r_job_count   <= '0;
         r_timeout_err <= 1'b0;
         r_done_prev   <= 1'b0;
         r_wait_cnt    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_done_prev <= core_done;
         r_wr_vis    <= r_wr_ptr;
         r_level     <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            {r_core_x, r_core_y, r_core_z} <= r_mem[r_rd_ptr[AW-1:0]];
         end
         if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_complete) begin
            r_job_count <= r_job_count + 8'd1;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_operand_dispatcher.sv
// Directed bench for operand_dispatcher (DEPTH=4, TIMEOUT=8): a vector table of
// single jobs plus hand-written sequences for queueing, timeout, wrap and reset.
module tb_operand_dispatcher;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_x = '0;
   logic [7:0] in_y = '0;
   logic [7:0] in_z = '0;
   logic       in_ready;
   logic [7:0] core_x, core_y, core_z;
   logic       core_start;
   logic       core_done = 1'b0;
   logic       busy;
   logic [7:0] job_count;
   logic       timeout_err;
   logic [2:0] fifo_level;

   operand_dispatcher #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_z       (in_z),
      .in_ready   (in_ready),
      .core_x     (core_x),
      .core_y     (core_y),
      .core_z     (core_z),
      .core_start (core_start),
      .core_done  (core_done),
      .busy       (busy),
      .job_count  (job_count),
      .timeout_err(timeout_err),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_acc  = 0;
   logic [23:0] push_q[$];

   // Upstream driver: presents the queue head, retires it on an accepted handshake.
   always @(posedge clk) begin
      if (in_valid && in_ready && push_q.size() > 0) begin
         void'(push_q.pop_front());
         n_acc++;
      end
      #2;
      if (push_q.size() > 0) begin
         in_valid = 1'b1;
         {in_x, in_y, in_z} = push_q[0];
      end else begin
         in_valid = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string nm, output int t);
      t = 0;
      while (!core_start && t < 30) begin
         step();
         t++;
      end
      check(nm, core_start, 1);
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      while (busy && t < 30) begin
         step();
         t++;
      end
      check(nm, busy, 0);
   endtask

   task automatic pulse_done();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_core_x"}, core_x, 0);
      check({tag, "_core_y"}, core_y, 0);
      check({tag, "_core_z"}, core_z, 0);
      check({tag, "_core_start"}, core_start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_job_count"}, job_count, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
      check({tag, "_fifo_level"}, fifo_level, 0);
   endtask

   task automatic do_reset(input string tag);
      push_q.delete();
      core_done = 1'b0;
      rst = 1'b1;
      #1;
      check_zero(tag);
      step();
      step();
      rst = 1'b0;
      step();
      check({tag, "_ready_after"}, in_ready, 1);
      n_acc = 0;
   endtask

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] z;
      int         dly;
      logic [7:0] exp_jc;
      logic       exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int t;
      int starts;

      // done delay is counted in cycles after the ISSUE cycle; 8 hits the expiry cycle
      vecs[0] = '{x: 8'd5,   y: 8'd71, z: 8'd255, dly: 4, exp_jc: 8'd1, exp_err: 1'b0};
      vecs[1] = '{x: 8'd1,   y: 8'd2,  z: 8'd3,   dly: 1, exp_jc: 8'd2, exp_err: 1'b0};
      vecs[2] = '{x: 8'd170, y: 8'd85, z: 8'd204, dly: 8, exp_jc: 8'd3, exp_err: 1'b0};
      vecs[3] = '{x: 8'd9,   y: 8'd8,  z: 8'd7,   dly: 9, exp_jc: 8'd3, exp_err: 1'b1};
      vecs[4] = '{x: 8'd255, y: 8'd0,  z: 8'd128, dly: 3, exp_jc: 8'd4, exp_err: 1'b1};

      #1;
      do_reset("rst0");

      for (int i = 0; i < 5; i++) begin
         push_q.push_back({vecs[i].x, vecs[i].y, vecs[i].z});
         step();
         check($sformatf("v%0d_start_n", i), core_start, 0);
         step();
         check($sformatf("v%0d_start_n1", i), core_start, 0);
         step();
         check($sformatf("v%0d_start_n2", i), core_start, 1);
         check($sformatf("v%0d_core_x", i), core_x, vecs[i].x);
         check($sformatf("v%0d_core_y", i), core_y, vecs[i].y);
         check($sformatf("v%0d_core_z", i), core_z, vecs[i].z);
         check($sformatf("v%0d_busy", i), busy, 1);
         step();
         check($sformatf("v%0d_start_n3", i), core_start, 0);
         repeat (vecs[i].dly - 1) step();
         pulse_done();
         wait_idle($sformatf("v%0d_idle", i));
         check($sformatf("v%0d_job_count", i), job_count, vecs[i].exp_jc);
         check($sformatf("v%0d_timeout_err", i), timeout_err, vecs[i].exp_err);
         check($sformatf("v%0d_hold_x", i), core_x, vecs[i].x);
         $display("job %0d (%0d,%0d,%0d) dly=%0d job_count=%0d timeout_err=%0d",
                  i, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].dly, job_count, timeout_err);
      end

      // core_done held high across two jobs: second sees no edge and times out
      do_reset("rst1");
      push_q.push_back(24'h111213);
      push_q.push_back(24'h212223);
      wait_start("hold_startA", t);
      step();
      core_done = 1'b1;
      wait_start("hold_startB", t);
      check("hold_B_x", core_x, 8'h21);
      wait_idle("hold_idle");
      check("hold_job_count", job_count, 1);
      check("hold_timeout_err", timeout_err, 1);
      core_done = 1'b0;
      $display("held-done: job_count=%0d timeout_err=%0d", job_count, timeout_err);

      // FIFO fills to 4 while a job is waiting; queued triples issue in order
      do_reset("rst2");
      push_q.push_back(24'h10AABB);
      wait_start("fill_startA", t);
      n_acc = 0;
      for (int j = 0; j < 5; j++) push_q.push_back({8'(8'h21 + j), 8'h00, 8'(j)});
      repeat (6) step();
      check("fill_level", fifo_level, 4);
      check("fill_in_ready", in_ready, 0);
      check("fill_accepted", n_acc, 4);
      pulse_done();
      for (int j = 0; j < 5; j++) begin
         wait_start($sformatf("fill_start%0d", j), t);
         check($sformatf("fill_order%0d", j), core_x, 8'h21 + j);
         check($sformatf("fill_z%0d", j), core_z, j);
         step();
         pulse_done();
         $display("queued job %0d issued x=%0h", j, core_x);
      end
      wait_idle("fill_idle");
      check("fill_job_count", job_count, 6);
      check("fill_empty", fifo_level, 0);

      // reset during WAIT with two triples queued
      for (int j = 0; j < 3; j++) push_q.push_back({8'(8'h31 + j), 8'h01, 8'h02});
      wait_start("mid_start", t);
      step();
      check("mid_busy", busy, 1);
      check("mid_level", fifo_level, 2);
      rst = 1'b1;
      #1;
      check_zero("mid");
      step();
      rst = 1'b0;
      step();
      check("mid_ready_after", in_ready, 1);
      starts = 0;
      for (int j = 0; j < 10; j++) begin
         step();
         if (core_start) starts++;
      end
      check("mid_no_start", starts, 0);
      $display("reset mid-job: starts after release=%0d", starts);

      // exact timeout boundary: still waiting after 7 WAIT cycles, aborted after 8
      push_q.push_back(24'h445566);
      wait_start("to_start", t);
      repeat (8) step();
      check("to_busy_before", busy, 1);
      check("to_err_before", timeout_err, 0);
      step();
      check("to_busy_after", busy, 0);
      check("to_err_after", timeout_err, 1);
      check("to_job_count", job_count, 0);
      push_q.push_back(24'h778899);
      wait_start("to_next_start", t);
      check("to_next_x", core_x, 8'h77);
      step();
      pulse_done();
      wait_idle("to_next_idle");
      check("to_next_job_count", job_count, 1);
      check("to_err_sticky", timeout_err, 1);
      $display("timeout: job_count=%0d timeout_err=%0d", job_count, timeout_err);

      // 256 back-to-back jobs wrap job_count to 0
      do_reset("rst3");
      for (int i = 0; i < 256; i++) push_q.push_back({8'(i), 8'(255 - i), 8'h5A});
      for (int i = 0; i < 256; i++) begin
         wait_start($sformatf("wrap_start%0d", i), t);
         if (i == 100) check("wrap_b2b_gap", t, 1);
         check($sformatf("wrap_x%0d", i), core_x, i);
         step();
         pulse_done();
         if (i == 254) check("wrap_jc255", job_count, 255);
      end
      wait_idle("wrap_idle");
      check("wrap_jc0", job_count, 0);
      check("wrap_err", timeout_err, 0);
      $display("wrap: 256 jobs job_count=%0d", job_count);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
